// File: rtl/axi_cache_pkg.sv
// Shared types and helpers for the cache line-fill miss engine.
// Beats are fixed at 8 bytes, matching the SIZE_8B request size.
package axi_cache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FILL    = 3'd5
    } fill_state_e;

    localparam logic [2:0]  SIZE_8B    = 3'd3;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam int unsigned BEAT_BYTES = 8;

    // Byte address of beat idx within the line starting at base (wraps modulo 2^64).
    function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [63:0] idx);
        return base + idx * 64'(BEAT_BYTES);
    endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Refill line buffer: BEATS x DATA_W registers, written one beat at a time by index
// and read out as a full line with beat 0 in the least significant bits.
module line_beat_buf #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 64
) (
    input  logic                     M_AXI_ACLK,
    input  logic                     M_AXI_ARESETN,
    input  logic                     wr_en,
    input  logic [$clog2(BEATS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [BEATS*DATA_W-1:0]  line_data
);

    logic [DATA_W-1:0] mem_q [BEATS];

    // NOTE: this storage is reset because its contents drive fill_data directly and must
    // read as zero after reset; sequential state uses <= so all registers update together.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            for (int i = 0; i < BEATS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line_data[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/axi_line_fill_ctrl.sv
// Line miss engine: optional victim write-back, then beat-by-beat refill via a single-beat driver.
// Define CRITICAL_WORD_FIRST_EN to start the refill at the missed beat and wrap around the line.
module axi_line_fill_ctrl
    import axi_cache_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LINE_BYTES     = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     miss_addr,
    input  logic                          miss_dirty,
    input  logic [AXI_ADDR_WIDTH-1:0]     victim_addr,
    input  logic [LINE_BYTES*8-1:0]       victim_data,
    output logic                          fill_valid,
    input  logic                          fill_ready,
    output logic [AXI_ADDR_WIDTH-1:0]     fill_addr,
    output logic [LINE_BYTES*8-1:0]       fill_data,
    output logic                          fill_err,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic                          req_is_write,
    output logic [AXI_ADDR_WIDTH-1:0]     req_addr,
    output logic [7:0]                    req_len,
    output logic [2:0]                    req_size,
    output logic [AXI_DATA_WIDTH-1:0]     req_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic                          rsp_valid,
    input  logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    input  logic                          rsp_err
);

    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~AXI_ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);

    fill_state_e state_q, state_d;

    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          rd_idx;
    logic [AXI_ADDR_WIDTH-1:0] miss_base_q;
    logic [AXI_ADDR_WIDTH-1:0] victim_base_q;
    logic [AXI_DATA_WIDTH-1:0] victim_q [BEATS];
    logic                      err_q;
    logic                      accept;
    logic                      rsp_fire;
    logic                      buf_we;

    assign accept   = miss_valid && (state_q == IDLE);
    assign rsp_fire = rsp_valid && ((state_q == WB_WAIT) || (state_q == RD_WAIT));
    assign buf_we   = rsp_valid && (state_q == RD_WAIT);

`ifdef CRITICAL_WORD_FIRST_EN
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int BOFF_W = $clog2(BEAT_BYTES);

    logic [CNT_W-1:0] start_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            start_q <= '0;
        end else if (accept) begin
            start_q <= miss_addr[OFF_W-1:BOFF_W];
        end
    end

    // Read order wraps from the critical beat; the counter still tracks beats issued.
    assign rd_idx = cnt_q + start_q;
`else
    assign rd_idx = cnt_q;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_valid) state_d = miss_dirty ? WB_REQ : RD_REQ;
            WB_REQ:  if (req_ready)  state_d = WB_WAIT;
            WB_WAIT: if (rsp_valid)  state_d = (cnt_q == LAST_BEAT) ? RD_REQ : WB_REQ;
            RD_REQ:  if (req_ready)  state_d = RD_WAIT;
            RD_WAIT: if (rsp_valid)  state_d = (cnt_q == LAST_BEAT) ? FILL : RD_REQ;
            FILL:    if (fill_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        miss_ready   = 1'b0;
        fill_valid   = 1'b0;
        req_valid    = 1'b0;
        req_is_write = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        unique case (state_q)
            IDLE: miss_ready = 1'b1;
            WB_REQ: begin
                req_valid    = 1'b1;
                req_is_write = 1'b1;
                req_addr     = AXI_ADDR_WIDTH'(beat_addr(64'(victim_base_q), 64'(cnt_q)));
                req_wdata    = victim_q[cnt_q];
            end
            RD_REQ: begin
                req_valid = 1'b1;
                req_addr  = AXI_ADDR_WIDTH'(beat_addr(64'(miss_base_q), 64'(rd_idx)));
            end
            FILL:    fill_valid = 1'b1;
            default: ;
        endcase
    end

    assign req_len   = 8'd0;
    assign req_size  = SIZE_8B;
    assign req_wstrb = {(AXI_DATA_WIDTH/8){req_is_write}};

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            cnt_q         <= '0;
            err_q         <= 1'b0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            for (int i = 0; i < BEATS; i++) begin
                victim_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q         <= '0;
            err_q         <= 1'b0;
            miss_base_q   <= miss_addr & LINE_MASK;
            victim_base_q <= victim_addr & LINE_MASK;
            for (int i = 0; i < BEATS; i++) begin
                victim_q[i] <= victim_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end else if (rsp_fire) begin
            // Errors are sticky and never cut a miss short; every beat is still issued.
            err_q <= err_q | rsp_err;
            cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        end
    end

    assign fill_addr = miss_base_q;
    assign fill_err  = err_q;

    line_beat_buf #(
        .BEATS  (BEATS),
        .DATA_W (AXI_DATA_WIDTH)
    ) u_line_buf (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .wr_en         (buf_we),
        .wr_idx        (rd_idx),
        .wr_data       (rsp_rdata),
        .line_data     (fill_data)
    );

endmodule
